// File: rtl/sme_match_collector.sv
// rtl/sme_match_collector.sv - match-report FWFT FIFO, saturating per-pattern hit counters, completion flag
// Accepts engine reports until finish, then drains the FIFO and raises done.
module sme_match_collector #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [3:0]       pattern_no,
    input  logic [11:0]      match_addr,
    input  logic             finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_pattern_no,
    output logic [11:0]      out_match_addr,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value,
    output logic             overflow,
    output logic             done
);
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] HIT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_hits [16];
    logic             r_overflow;
    logic             r_done;

    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic             w_push;
    logic [15:0]      w_head;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_pop    = (r_count != '0) && out_ready;
    assign w_accept = valid && (r_state == ST_COLLECT);
    // A full FIFO still takes the report when the head leaves in the same cycle.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_head   = r_mem[r_rd_ptr];

    assign out_valid      = (r_count != '0);
    assign out_pattern_no = w_head[15:12];
    assign out_match_addr = w_head[11:0];
    assign cnt_value      = r_hits[cnt_sel];
    assign overflow       = r_overflow;
    assign done           = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pattern_no, match_addr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_COLLECT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_COLLECT: begin
                    if (finish) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_hits[i] <= '0;
            end
        end else if (w_accept && (r_hits[pattern_no] != '1)) begin
            r_hits[pattern_no] <= r_hits[pattern_no] + HIT_ONE;
        end
    end
endmodule

// File: tb/tb_sme_match_collector.sv
// tb/tb_sme_match_collector.sv - self-checking bench for sme_match_collector
// Two instances share stimulus: CNT_W=12 and CNT_W=4 (saturation).
module tb_sme_match_collector;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  pattern_no = '0;
    logic [11:0] match_addr = '0;
    logic        finish = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  cnt_sel = '0;

    logic        out_valid, out_valid_s;
    logic [3:0]  out_pattern_no, out_pattern_no_s;
    logic [11:0] out_match_addr, out_match_addr_s;
    logic [11:0] cnt_value;
    logic [3:0]  cnt_value_s;
    logic        overflow, overflow_s;
    logic        done, done_s;

    always #5 clk = ~clk;

    sme_match_collector #(.FIFO_DEPTH(DEPTH), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .valid(valid), .pattern_no(pattern_no),
        .match_addr(match_addr), .finish(finish), .out_valid(out_valid),
        .out_ready(out_ready), .out_pattern_no(out_pattern_no),
        .out_match_addr(out_match_addr), .cnt_sel(cnt_sel), .cnt_value(cnt_value),
        .overflow(overflow), .done(done)
    );

    sme_match_collector #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .valid(valid), .pattern_no(pattern_no),
        .match_addr(match_addr), .finish(finish), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_pattern_no(out_pattern_no_s),
        .out_match_addr(out_match_addr_s), .cnt_sel(cnt_sel), .cnt_value(cnt_value_s),
        .overflow(overflow_s), .done(done_s)
    );

    typedef struct packed {
        logic [3:0]  pat;
        logic [11:0] addr;
    } entry_t;

    typedef struct {
        logic        v;
        logic [3:0]  p;
        logic [11:0] a;
        logic        f;
        logic        r;
        logic [3:0]  s;
        logic        rst;
        logic        e_ov;
        logic [3:0]  e_pat;
        logic [11:0] e_addr;
        logic [11:0] e_cnt;
        logic        e_done;
    } vec_t;

    // Reference: report queue, unbounded hit totals, phase 0=collect 1=drain 2=done.
    entry_t m_q[$];
    int     m_hits[16];
    bit     m_overflow;
    int     m_phase;
    entry_t popped[$];

    int n_checks = 0;
    int n_fail = 0;
    vec_t vt[12];
    int fin_at;
    int rp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input logic v, input logic [3:0] p, input logic [11:0] a,
                              input logic f, input logic r);
        bit was_empty;
        entry_t e;
        was_empty = (m_q.size() == 0);
        if (!was_empty && r) void'(m_q.pop_front());
        if (m_phase == 0 && v) begin
            m_hits[p]++;
            if (m_q.size() < DEPTH) begin
                e.pat = p;
                e.addr = a;
                m_q.push_back(e);
            end else begin
                m_overflow = 1'b1;
            end
        end
        if (m_phase == 0 && f) m_phase = 1;
        else if (m_phase == 1 && was_empty) m_phase = 2;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_valid_s", 32'(out_valid_s), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("head_pat", 32'(out_pattern_no), 32'(m_q[0].pat));
            chk("head_addr", 32'(out_match_addr), 32'(m_q[0].addr));
            chk("head_addr_s", 32'(out_match_addr_s), 32'(m_q[0].addr));
        end
        chk("overflow", 32'(overflow), 32'(m_overflow));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("done_s", 32'(done_s), 32'(m_phase == 2));
        chk("cnt", 32'(cnt_value), sat(m_hits[cnt_sel], 4095));
        chk("cnt_s", 32'(cnt_value_s), sat(m_hits[cnt_sel], 15));
    endtask

    task automatic step(input logic v, input logic [3:0] p, input logic [11:0] a,
                        input logic f, input logic r, input logic [3:0] s);
        entry_t e;
        valid = v;
        pattern_no = p;
        match_addr = a;
        finish = f;
        out_ready = r;
        cnt_sel = s;
        #1;
        if (out_valid && r) begin
            e.pat = out_pattern_no;
            e.addr = out_match_addr;
            popped.push_back(e);
        end
        @(posedge clk);
        model_step(v, p, a, f, r);
        @(negedge clk);
        check_all();
    endtask

    // Reset is raised between edges so the outputs must clear without a clock.
    task automatic do_reset();
        valid = 1'b0;
        finish = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        m_q.delete();
        m_hits = '{default: 0};
        m_overflow = 1'b0;
        m_phase = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_valid_s", 32'(out_valid_s), 32'd0);
        for (int s = 0; s < 16; s++) begin
            cnt_sel = 4'(s);
            #1;
            chk("rst_cnt", 32'(cnt_value), 32'd0);
            chk("rst_cnt_s", 32'(cnt_value_s), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        popped.delete();
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'd3, 12'h010, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd3, 12'h010, 12'd1, 1'b0};
        vt[1]  = '{1'b1, 4'd3, 12'h0A5, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 4'd3, 12'h010, 12'd2, 1'b0};
        vt[2]  = '{1'b1, 4'd7, 12'hFFF, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 4'd3, 12'h010, 12'd1, 1'b0};
        vt[3]  = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 4'd3, 12'h0A5, 12'd0, 1'b0};
        vt[4]  = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 4'd7, 12'hFFF, 12'd2, 1'b0};
        vt[5]  = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 12'h000, 12'd1, 1'b0};
        vt[6]  = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 12'h000, 12'd2, 1'b0};
        vt[7]  = '{1'b1, 4'd2, 12'h123, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 4'd2, 12'h123, 12'd1, 1'b0};
        vt[8]  = '{1'b1, 4'd2, 12'h456, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 4'd2, 12'h123, 12'd1, 1'b0};
        vt[9]  = '{1'b1, 4'd4, 12'h777, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 12'h000, 12'd0, 1'b0};
        vt[10] = '{1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 12'h000, 12'd1, 1'b1};
        vt[11] = '{1'b1, 4'd2, 12'h001, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 12'h000, 12'd1, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (vt[i].rst) do_reset();
            step(vt[i].v, vt[i].p, vt[i].a, vt[i].f, vt[i].r, vt[i].s);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            if (vt[i].e_ov) begin
                chk($sformatf("tbl%0d_pat", i), 32'(out_pattern_no), 32'(vt[i].e_pat));
                chk($sformatf("tbl%0d_addr", i), 32'(out_match_addr), 32'(vt[i].e_addr));
            end
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt_value), 32'(vt[i].e_cnt));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].e_done));
        end

        // Seventeen reports into a 16-deep FIFO: the last one is dropped.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 4'd1, 12'(i), 1'b0, 1'b0, 4'd1);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_cnt1", 32'(cnt_value), 32'd17);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 12'h0, 1'b0, 1'b1, 4'd1);
        chk("t2_npop", popped.size(), 32'd16);
        for (int i = 0; i < popped.size() && i < 16; i++) chk("t2_addr", 32'(popped[i].addr), i);

        // Push and pop together at full keeps occupancy at 16.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'd6, 12'(i), 1'b0, 1'b0, 4'd6);
        step(1'b1, 4'd6, 12'hABC, 1'b0, 1'b1, 4'd6);
        chk("t3_overflow_simul", 32'(overflow), 32'd0);
        step(1'b1, 4'd6, 12'hDEF, 1'b0, 1'b0, 4'd6);
        chk("t3_overflow_full", 32'(overflow), 32'd1);
        chk("t3_cnt6", 32'(cnt_value), 32'd18);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 12'h0, 1'b0, 1'b1, 4'd6);
        chk("t3_npop", popped.size(), 32'd17);
        if (popped.size() == 17) begin
            chk("t3_first", 32'(popped[0].addr), 32'd0);
            chk("t3_last", 32'(popped[16].addr), 32'hABC);
        end

        // Saturation at 15 on the narrow-counter instance.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 4'd5, 12'(i), 1'b0, 1'b1, 4'd5);
        chk("t5_cnt_sat", 32'(cnt_value_s), 32'd15);
        chk("t5_cnt_wide", 32'(cnt_value), 32'd20);
        chk("t5_overflow", 32'(overflow), 32'd0);

        // Reset while draining with entries still buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 4'd9, 12'(i + 100), 1'b0, 1'b0, 4'd9);
        step(1'b0, 4'd0, 12'h0, 1'b1, 1'b0, 4'd9);
        step(1'b0, 4'd0, 12'h0, 1'b0, 1'b1, 4'd9);
        step(1'b0, 4'd0, 12'h0, 1'b0, 1'b1, 4'd9);
        chk("t6_pre_out_valid", 32'(out_valid), 32'd1);
        do_reset();
        step(1'b1, 4'd8, 12'h321, 1'b0, 1'b0, 4'd8);
        chk("t6_post_out_valid", 32'(out_valid), 32'd1);
        chk("t6_post_addr", 32'(out_match_addr), 32'h321);
        chk("t6_post_cnt", 32'(cnt_value), 32'd1);

        // Randomized runs with finish held high once raised.
        for (int run = 0; run < 6; run++) begin
            do_reset();
            fin_at = $urandom_range(80, 280);
            rp = (run % 3 == 0) ? 20 : ((run % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 300; c++) begin
                step(($urandom % 100) < 60, 4'($urandom_range(0, 3)), 12'($urandom),
                     c >= fin_at, ($urandom % 100) < rp, 4'($urandom_range(0, 4)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sme_match_collector.md
# sme_match_collector

Result sink for the string-matching engine. Captures every `valid` match report (`pattern_no`, `match_addr`) into a first-word-fall-through FIFO and keeps a saturating hit counter per pattern. The FIFO is drained downstream through a ready/valid port. After the engine raises `finish` and the FIFO is drained, the block signals `done`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: number of match entries buffered; must be a power of two, ≥ 2.
- `CNT_W`, 12: width of each per-pattern hit counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `valid` input 1: engine match strobe, one report per high cycle.
- `pattern_no` input 4: pattern index of the report.
- `match_addr` input 12: text address of the report.
- `finish` input 1: engine completion; may stay high after its first assertion.
- `out_valid` output 1: FIFO head is available.
- `out_ready` input 1: downstream accepts the head. A pop occurs when `out_valid && out_ready`.
- `out_pattern_no` output 4: FIFO head pattern index.
- `out_match_addr` output 12: FIFO head address.
- `cnt_sel` input 4: selects the hit counter to read.
- `cnt_value` output CNT_W: hit count of pattern `cnt_sel`; combinational read.
- `overflow` output 1: sticky; set when a report was dropped because the FIFO was full.
- `done` output 1: the engine has finished and all buffered reports have been popped.

## Operation
- State machine: COLLECT → DRAIN → DONE. Reset enters COLLECT.
- COLLECT
  - A report is accepted when `valid` is high.
  - On acceptance, counter[`pattern_no`] increments, saturating at 2^CNT_W−1.
  - The report is pushed if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the push is dropped and `overflow` is set. The counter still increments.
  - `finish` high moves the machine to DRAIN. A `valid` in that same cycle is still accepted.
- DRAIN
  - `valid` is ignored: no push, no count.
  - Pops continue.
  - When the FIFO count is 0, move to DONE.
- DONE
  - `done` = 1. Inputs are ignored except pops, and the FIFO is already empty.
  - Exit only by `reset`.
- FIFO
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - The occupancy count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
  - A pop while empty is impossible, because `out_valid` = 0.
- Outputs
  - `out_valid` = (count != 0).
  - `out_pattern_no` and `out_match_addr` show the entry at the read pointer. Their value is don't-care when `out_valid` = 0.
- Reset, asserted at any time including mid-drain:
  - FIFO is emptied and the state returns to COLLECT.
  - All counters are cleared to 0.
  - `overflow` = 0, `done` = 0, `out_valid` = 0.

## Timing
- Report latency: `valid` sampled at edge k with the FIFO empty → `out_valid` = 1 after edge k. The head values are valid in the same cycle.
- Counter update: visible on `cnt_value` after the sampling edge.
- Done latency: `finish` sampled at edge k gives state DRAIN after edge k. If the FIFO is empty at edge k+1, `done` = 1 after edge k+1.
- Done after the last pop: `done` rises one cycle after the edge of the final pop.
- `out_valid` holds, with the head stable, until a pop. There is no combinational path from `out_ready` to `out_valid`.
- `overflow` sets on the edge of the dropped push and holds until reset.

## Test plan
1. Basic capture and read-back
   - Stimulus: with `out_ready` = 0, send three reports: (3, 0x010), (3, 0x0A5), (7, 0xFFF). Then set `out_ready` = 1.
   - Required response: the pops emerge in that order, one per cycle. Reading `cnt_sel` = 3 gives 2, `cnt_sel` = 7 gives 1, `cnt_sel` = 0 gives 0.
2. Full FIFO and overflow
   - Stimulus: with `out_ready` = 0, send 17 reports (pattern 1, addresses 0..16) at FIFO_DEPTH = 16.
   - Required response: `overflow` = 1 after the 17th report. Draining yields addresses 0..15 only. Counter 1 = 17.
3. Simultaneous push and pop at full
   - Stimulus: fill the FIFO to 16 entries, then assert `valid` and `out_ready` in the same cycle.
   - Required response: the count stays 16, `overflow` stays 0, and the new entry is popped last.
4. Finish handling
   - Stimulus: `valid` and `finish` together (pattern 2, 0x123), then more `valid`s, then a drain.
   - Required response: exactly one entry is output, counter 2 = 1, and `done` = 1 one cycle after the pop.
5. Counter saturation
   - Stimulus: with CNT_W = 4, send 20 reports for pattern 5 while draining continuously.
   - Required response: counter 5 = 15.
6. Reset mid-drain
   - Stimulus: enter DRAIN with 5 entries buffered, pop 2, then assert `reset`.
   - Required response: `out_valid` = 0, `done` = 0, `overflow` = 0, and all counters = 0. After release, new reports are accepted in COLLECT.
